id_operand_fetch: RTL and testbench

- ID-stage consumer of the bypass bus produced by the bypass collector.
- Resolves the rj/rk source operands each cycle with priority EXE > MEM > WB > register file.
- Raises a load-use interlock when the matching producer's data is not yet valid.
- Latches resolved operands while the instruction waits for EXE to accept it, so the values stay stable after the producer retires.

---
 rtl/id_operand_fetch.sv | 243 ++++++++++++++++++++++++
 tb/tb_id_operand_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_fetch.sv
// id_operand_fetch: ID-stage operand resolver sitting on the bypass bus.
// For each cycle it resolves the rj/rk operands with priority
// EXE > MEM > WB > register file. If the winning producer's data is not
// ready yet, it raises a load-use interlock. When EXE is not ready to accept
// the instruction, it latches the resolved operands so they stay stable.
// Optional feature (macro ID_STALL_PERF_CNT_EN): saturating stall-cycle
// counter exposed on output stall_cnt.
module id_operand_fetch #(
  parameter int BY_BUS_WD    = 120,
  parameter int STALL_CNT_WD = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [BY_BUS_WD-1:0] BY_to_ID_bus,
  input  logic                 id_valid,
  input  logic                 id_flush,
  input  logic                 rj_read,
  input  logic                 rk_read,
  input  logic [4:0]           rj_addr,
  input  logic [4:0]           rk_addr,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  input  logic                 exe_allowin,
  output logic [31:0]          src1_data,
  output logic [31:0]          src2_data,
  output logic                 id_ready_go,
  output logic                 id_to_exe_valid,
  output logic [1:0]           fwd_state
`ifdef ID_STALL_PERF_CNT_EN
  ,
  output logic [STALL_CNT_WD-1:0] stall_cnt
`endif
);

  // Each bypass stage slot is {addr, data, data_valid, valid, rf_w_en}.
  localparam int STG_WD = 40;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        data_valid;
    logic        valid;
    logic        rf_w_en;
  } by_stage_t;

  // Result of resolving one source operand.
  typedef struct packed {
    logic        haz;
    logic [31:0] data;
  } resolve_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef logic [STALL_CNT_WD-1:0] stall_cnt_t;

  by_stage_t   stg_exe;
  by_stage_t   stg_mem;
  by_stage_t   stg_wb;

  resolve_t    res_j;
  resolve_t    res_k;
  logic        hazard;
  logic        latch_en;
  logic        ready_raw;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] src1_lat_q;
  logic [31:0] src1_lat_d;
  logic [31:0] src2_lat_q;
  logic [31:0] src2_lat_d;

  // A stage forwards to a source only if it really writes the register and
  // the instruction actually reads that register. r0 never matches.
  function automatic logic stage_hit(input by_stage_t  s,
                                     input logic [4:0] addr,
                                     input logic       rd);
    return rd & s.valid & s.rf_w_en & (s.addr == addr) & (addr != 5'd0);
  endfunction

  // The first matching stage in priority order decides the result. If its
  // data is not ready, the source is hazarded, and lower-priority copies are
  // deliberately ignored because they hold stale values.
  function automatic resolve_t resolve_src(input by_stage_t   e,
                                           input by_stage_t   m,
                                           input by_stage_t   w,
                                           input logic [4:0]  addr,
                                           input logic        rd,
                                           input logic [31:0] rf);
    resolve_t r;
    r.haz  = 1'b0;
    r.data = rf;
    if (addr == 5'd0) begin
      r.data = 32'h0;
    end else if (stage_hit(e, addr, rd)) begin
      r.data = e.data;
      r.haz  = ~e.data_valid;
    end else if (stage_hit(m, addr, rd)) begin
      r.data = m.data;
      r.haz  = ~m.data_valid;
    end else if (stage_hit(w, addr, rd)) begin
      r.data = w.data;
      r.haz  = ~w.data_valid;
    end
    return r;
  endfunction

  // Split the bypass bus into its stage slots. EXE occupies the top slot.
  always_comb begin
    stg_exe = by_stage_t'(BY_to_ID_bus[BY_BUS_WD-1          -: STG_WD]);
    stg_mem = by_stage_t'(BY_to_ID_bus[BY_BUS_WD-1-STG_WD   -: STG_WD]);
    stg_wb  = by_stage_t'(BY_to_ID_bus[BY_BUS_WD-1-2*STG_WD -: STG_WD]);
  end

  // Resolve both sources combinationally so there is no added latency.
  always_comb begin
    res_j  = resolve_src(stg_exe, stg_mem, stg_wb, rj_addr, rj_read, rf_rdata1);
    res_k  = resolve_src(stg_exe, stg_mem, stg_wb, rk_addr, rk_read, rf_rdata2);
    hazard = id_valid & (res_j.haz | res_k.haz);
  end

  // Next-state logic for the interlock FSM, and the operand latch enable.
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    ready_raw = 1'b0;
    case (state_q)
      ST_RUN: begin
        ready_raw = ~hazard;
        if (id_valid & hazard) begin
          state_d = ST_STALL;
        end else if (id_valid & ~exe_allowin) begin
          state_d  = ST_HOLD;
          latch_en = 1'b1;
        end
      end
      ST_STALL: begin
        ready_raw = ~hazard;
        if (~id_valid) begin
          state_d = ST_RUN;
        end else if (~hazard) begin
          if (exe_allowin) begin
            state_d = ST_RUN;
          end else begin
            state_d  = ST_HOLD;
            latch_en = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        ready_raw = 1'b1;
        if (~id_valid | exe_allowin) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // A flush abandons the instruction, so nothing is worth latching.
    if (id_flush) begin
      state_d  = ST_RUN;
      latch_en = 1'b0;
    end
  end

  // Capture the resolved operands on the edge that enters HOLD.
  always_comb begin
    src1_lat_d = src1_lat_q;
    src2_lat_d = src2_lat_q;
    if (latch_en) begin
      src1_lat_d = res_j.data;
      src2_lat_d = res_k.data;
    end
  end

  // State and latched-operand registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_RUN;
      src1_lat_q <= 32'h0;
      src2_lat_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      src1_lat_q <= src1_lat_d;
      src2_lat_q <= src2_lat_d;
    end
  end

  // Output muxing. HOLD serves the latched copies, so a producer retiring
  // from WB cannot change operands that are already committed.
  always_comb begin
    src1_data = 32'h0;
    src2_data = 32'h0;
    if (id_valid) begin
      if (state_q == ST_HOLD) begin
        src1_data = src1_lat_q;
        src2_data = src2_lat_q;
      end else begin
        src1_data = res_j.data;
        src2_data = res_k.data;
      end
    end
    id_ready_go     = resetn & id_valid & ready_raw;
    id_to_exe_valid = id_ready_go & ~id_flush;
    fwd_state       = state_q;
  end

`ifdef ID_STALL_PERF_CNT_EN
  stall_cnt_t stall_cnt_q;
  stall_cnt_t stall_cnt_d;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic stall_cnt_t sat_inc(input stall_cnt_t v);
    return (&v) ? v : v + stall_cnt_t'(1);
  endfunction

  // Count every cycle spent interlocked, including the cycle that detects
  // the hazard while still in RUN.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_STALL) | ((state_q == ST_RUN) & hazard)) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_fetch.sv
// Bench for id_operand_fetch: directed scenarios plus randomized cycles,
// all compared against a behavioural reference model.
module tb_id_operand_fetch;

  localparam int BW = 120;
  localparam int CW = 16;
  localparam int MS_RUN   = 0;
  localparam int MS_STALL = 1;
  localparam int MS_HOLD  = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic [BW-1:0] bus;
  logic          id_valid, id_flush, rj_read, rk_read, exe_allowin;
  logic [4:0]    rj_addr, rk_addr;
  logic [31:0]   rf_rdata1, rf_rdata2;
  logic [31:0]   src1_data, src2_data;
  logic          id_ready_go, id_to_exe_valid;
  logic [1:0]    fwd_state;
`ifdef ID_STALL_PERF_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  id_operand_fetch #(.BY_BUS_WD(BW), .STALL_CNT_WD(CW)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .BY_to_ID_bus    (bus),
    .id_valid        (id_valid),
    .id_flush        (id_flush),
    .rj_read         (rj_read),
    .rk_read         (rk_read),
    .rj_addr         (rj_addr),
    .rk_addr         (rk_addr),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .exe_allowin     (exe_allowin),
    .src1_data       (src1_data),
    .src2_data       (src2_data),
    .id_ready_go     (id_ready_go),
    .id_to_exe_valid (id_to_exe_valid),
    .fwd_state       (fwd_state)
`ifdef ID_STALL_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int          m_state;
  logic [31:0] m_lat1, m_lat2;
  int          m_cnt;
  logic        cur_haz;
  logic [31:0] cur_r1, cur_r2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = MS_RUN;
    m_lat1  = 32'h0;
    m_lat2  = 32'h0;
    m_cnt   = 0;
  endtask

  // Scan stages in priority order; the first writer of the register decides.
  function automatic void ref_resolve(input logic [BW-1:0] b, input logic [4:0] a,
                                      input logic rd, input logic [31:0] rf,
                                      output logic [31:0] d, output logic h);
    logic [39:0] f;
    d = rf;
    h = 1'b0;
    if (a == 5'd0) begin
      d = 32'h0;
      return;
    end
    for (int s = 0; s < 3; s++) begin
      f = b[(2-s)*40 +: 40];
      if (rd && f[1] && f[0] && f[39:35] == a) begin
        d = f[34:3];
        h = !f[2];
        return;
      end
    end
  endfunction

  task automatic put(input int s, input logic [4:0] a, input logic [31:0] d,
                     input logic dv, input logic v, input logic w);
    bus[(2-s)*40 +: 40] = {a, d, dv, v, w};
  endtask

  // Compare all outputs against the model at the falling edge.
  task automatic settle();
    logic h1, h2, rdy;
    @(negedge clk);
    ref_resolve(bus, rj_addr, rj_read, rf_rdata1, cur_r1, h1);
    ref_resolve(bus, rk_addr, rk_read, rf_rdata2, cur_r2, h2);
    cur_haz = id_valid && (h1 || h2);
    rdy = resetn && id_valid && ((m_state == MS_HOLD) ? 1'b1 : !cur_haz);
    chk("fwd_state", {30'h0, fwd_state}, m_state);
    chk("ready_go", {31'h0, id_ready_go}, {31'h0, rdy});
    chk("to_exe_valid", {31'h0, id_to_exe_valid}, {31'h0, rdy && !id_flush});
    if (id_valid) begin
      if (m_state == MS_HOLD) begin
        chk("src1_hold", src1_data, m_lat1);
        chk("src2_hold", src2_data, m_lat2);
      end else begin
        if (!h1) chk("src1", src1_data, cur_r1);
        if (!h2) chk("src2", src2_data, cur_r2);
      end
    end
`ifdef ID_STALL_PERF_CNT_EN
    chk("stall_cnt", {16'h0, stall_cnt}, m_cnt);
`endif
  endtask

  // Advance the model by one clock edge, then move the bench past that edge.
  task automatic advance();
    if (!resetn) begin
      model_reset();
    end else begin
      if (m_state == MS_STALL || (m_state == MS_RUN && cur_haz)) begin
        if (m_cnt < 65535) m_cnt++;
      end
      if (id_flush) begin
        m_state = MS_RUN;
      end else if (m_state == MS_HOLD) begin
        if (!id_valid || exe_allowin) m_state = MS_RUN;
      end else if (!id_valid) begin
        m_state = MS_RUN;
      end else if (cur_haz) begin
        m_state = MS_STALL;
      end else if (!exe_allowin) begin
        m_state = MS_HOLD;
        m_lat1  = cur_r1;
        m_lat2  = cur_r2;
      end else begin
        m_state = MS_RUN;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; bus = '0; id_valid = 0; id_flush = 0; rj_read = 0; rk_read = 0;
    rj_addr = 0; rk_addr = 0; rf_rdata1 = 0; rf_rdata2 = 0; exe_allowin = 0;
    model_reset();

    // Reset state
    settle();
    chk("rst_src1", src1_data, 32'h0);
    chk("rst_src2", src2_data, 32'h0);
    chk("rst_rdy", {31'h0, id_ready_go}, 32'h0);
    advance();
    resetn = 1'b1;

    // Forwarding from EXE wins over the register file in the same cycle
    id_valid = 1; exe_allowin = 1; rj_read = 1; rj_addr = 5; rf_rdata1 = 32'h1111;
    put(0, 5, 32'hAAAA, 1, 1, 1);
    settle();
    chk("nohaz_src1", src1_data, 32'hAAAA);
    chk("nohaz_rdy", {31'h0, id_ready_go}, 32'h1);
    advance();

    // Priority EXE > MEM > WB
    bus = '0; rj_addr = 3;
    put(0, 3, 32'h1, 1, 1, 1); put(1, 3, 32'h2, 1, 1, 1); put(2, 3, 32'h3, 1, 1, 1);
    settle(); chk("prio_exe", src1_data, 32'h1); advance();
    put(0, 3, 32'h1, 1, 0, 1);
    settle(); chk("prio_mem", src1_data, 32'h2); advance();
    put(1, 3, 32'h2, 1, 0, 1);
    settle(); chk("prio_wb", src1_data, 32'h3); advance();

    // Load-use interlock
    bus = '0; rj_read = 0; rk_read = 1; rk_addr = 7; rf_rdata2 = 32'h7777;
    put(0, 7, 32'h0, 0, 1, 1);
    settle(); chk("lu_rdy", {31'h0, id_ready_go}, 32'h0); advance();
    chk("lu_state", {30'h0, fwd_state}, 32'd1);
    bus = '0; put(1, 7, 32'hBEEF, 1, 1, 1);
    settle(); chk("lu_src2", src2_data, 32'hBEEF); advance();
    chk("lu_run", {30'h0, fwd_state}, 32'd0);

    // HOLD keeps the latched operand while WB retires
    bus = '0; rk_read = 0; rj_read = 1; rj_addr = 9; rf_rdata1 = 32'h1234; exe_allowin = 0;
    put(2, 9, 32'hCAFE, 1, 1, 1);
    settle(); chk("hold_res", src1_data, 32'hCAFE); advance();
    bus = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_src1", src1_data, 32'hCAFE);
      chk("hold_state", {30'h0, fwd_state}, 32'd2);
      advance();
    end
    exe_allowin = 1;
    settle(); advance();
    chk("hold_exit", {30'h0, fwd_state}, 32'd0);

    // r0 always reads as zero; flush from STALL
    bus = '0; rj_addr = 0; put(0, 0, 32'hFFFF, 1, 1, 1);
    settle();
    chk("r0_src1", src1_data, 32'h0);
    chk("r0_rdy", {31'h0, id_ready_go}, 32'h1);
    advance();
    bus = '0; rj_read = 0; rk_read = 1; rk_addr = 7; put(0, 7, 32'h0, 0, 1, 1);
    settle(); advance();
    id_flush = 1;
    settle(); chk("flush_tev", {31'h0, id_to_exe_valid}, 32'h0); advance();
    chk("flush_run", {30'h0, fwd_state}, 32'd0);
    id_flush = 0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 3; s++)
        put(s, 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 3) != 0));
      id_valid    = ($urandom_range(0, 7) != 0);
      id_flush    = ($urandom_range(0, 15) == 0);
      exe_allowin = 1'($urandom);
      rj_read     = 1'($urandom);
      rk_read     = 1'($urandom);
      rj_addr     = 5'($urandom_range(0, 7));
      rk_addr     = 5'($urandom_range(0, 7));
      rf_rdata1   = $urandom;
      rf_rdata2   = $urandom;
      settle();
      advance();
    end
    id_flush = 0;

    // Asynchronous reset in the middle of HOLD
    bus = '0; id_valid = 1; rk_read = 0; rj_read = 1; rj_addr = 9; exe_allowin = 0;
    put(2, 9, 32'hCAFE, 1, 1, 1);
    settle(); advance();
    settle();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("arst_state", {30'h0, fwd_state}, 32'd0);
    chk("arst_rdy", {31'h0, id_ready_go}, 32'h0);
    id_valid = 0;
    settle();
    chk("arst_src1", src1_data, 32'h0);
    chk("arst_src2", src2_data, 32'h0);
    advance();
    resetn = 1'b1;

    // Four interlocked cycles
    bus = '0; id_valid = 1; exe_allowin = 1; rj_read = 0; rk_read = 1; rk_addr = 7;
    put(0, 7, 32'h0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      settle();
      advance();
    end
`ifdef ID_STALL_PERF_CNT_EN
    chk("stall_cnt4", {16'h0, stall_cnt}, 32'd4);
`endif
    chk("stall_state", {30'h0, fwd_state}, 32'd1);
    bus = '0;
    settle();
    advance();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
